onchip_mem_stream_reader: RTL

// - Avalon-MM read master that pulls a block of words from the on-chip memory s1 slave.
// - Emits the words, in address order, on a valid/ready stream (e.g. toward the UART TX path).
// - Fixed read latency (memory has no waitrequest on s1; waitrequest is still honoured).
// - Credit-based: never issues a read it cannot buffer, so stream backpressure never loses data.

---
 rtl/onchip_mem_stream_reader.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/onchip_mem_stream_reader.sv
// onchip_mem_stream_reader
//   Avalon-MM read master that fetches a block of consecutive words from an
//   on-chip memory slave and replays them, in address order, on a valid/ready
//   stream. Reads are only issued when the output buffer is guaranteed to have
//   room for the returning word, so stream backpressure can never drop data.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   start               1-cycle request, sampled only while idle
//   start_addr          first word address of the block
//   word_count          number of words (0 = empty transfer, done only)
//   busy                transfer in progress
//   done                1-cycle completion pulse
//   avm_*               Avalon-MM read master toward the memory slave
//   st_data/st_valid    output stream, accepted when st_valid & st_ready
//   st_ready            stream sink ready
//
// State table
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_ISSUE | issuing reads while words remain and buffer credit exists
//   S_DRAIN | all reads issued, waiting for returns and stream to empty
//   S_DONE  | done pulse for one cycle, then back to idle

module onchip_mem_stream_reader #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [15:0]         word_count,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_read,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  input  logic                st_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_W-1:0]       addr;
  logic [15:0]             remaining;
  logic [CNT_W-1:0]        inflight;
  logic [CNT_W-1:0]        fifo_count;
  logic [READ_LATENCY-1:0] ret_pipe;
  logic [DATA_W-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;

  logic credit_ok;
  logic accept;
  logic ret;
  logic push;
  logic pop;

  // Credit counts words already in flight plus words buffered, so every
  // accepted read is guaranteed a FIFO slot when its data returns.
  assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < SUM_W'(FIFO_DEPTH);
  assign accept    = avm_read & ~avm_waitrequest;
  assign ret       = ret_pipe[READ_LATENCY-1];
  assign push      = ret;
  assign pop       = st_valid & st_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (word_count != 16'd0) ? S_ISSUE : S_DONE;
      end
      S_ISSUE: begin
        if (accept && remaining == 16'd1) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Nothing left in flight and the last buffered word leaves now:
        // done lands in the cycle right after the final beat.
        if (inflight == '0 && fifo_count == CNT_W'(1) && pop) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    avm_read = 1'b0;
    case (state)
      S_ISSUE: begin
        busy     = 1'b1;
        avm_read = (remaining != 16'd0) && credit_ok;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign avm_chipselect = avm_read;
  assign avm_address    = addr;
  assign avm_byteenable = '1;

  // Address / word counter. Credit can only grow during a stall, so
  // avm_read and the address stay stable while waitrequest is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (state == S_IDLE && start && word_count != 16'd0) begin
      addr      <= start_addr;
      remaining <= word_count;
    end else if (accept) begin
      addr      <= addr + ADDR_W'(1);
      remaining <= remaining - 16'd1;
    end
  end

  // Read-return tracking: one accept flag per latency stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ret_pipe <= '0;
      inflight <= '0;
    end else begin
      ret_pipe[0] <= accept;
      for (int i = 1; i < READ_LATENCY; i++) ret_pipe[i] <= ret_pipe[i-1];
      inflight <= inflight + CNT_W'(accept) - CNT_W'(ret);
    end
  end

  // Output FIFO bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset; occupancy is governed by fifo_count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= avm_readdata;
  end

  assign st_valid = (fifo_count != '0);
  assign st_data  = fifo_mem[rd_ptr];

endmodule
